// File: rtl/frame_scheduler_pkg.sv
// Shared types, default constants and the READ command builder for the
// frame scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT
  } sched_state_t;

  localparam int unsigned TICK_PERIOD_DEF = 2097152;
  localparam int unsigned NUM_LAYERS_DEF  = 3;
  localparam int unsigned FRAME_BYTES_DEF = 1024;
  localparam int unsigned BELL_OFFSET_DEF = 132;
  localparam int unsigned BELL_FRAMES_DEF = 300;
  localparam logic [7:0]  CMD_READ_DEF    = 8'h03;

  // Byte address is taken modulo 2^24, so a 24-bit product is exactly enough.
  function automatic logic [31:0] read_cmd(input logic [15:0] idx,
                                           input logic [7:0]  opcode,
                                           input int unsigned frame_bytes);
    logic [23:0] addr;
    addr = 24'(idx) * 24'(frame_bytes);
    return {opcode, addr};
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Request/ack/done handshake between the frame scheduler and the SPI
// shift reader.
interface frame_scheduler_if;
  logic        rd_req;
  logic [31:0] rd_cmd;
  logic        rd_first;
  logic        rd_ack;
  logic        rd_done;

  modport master (output rd_req, rd_cmd, rd_first, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_cmd, rd_first, output rd_ack, rd_done);
endinterface

// File: rtl/frame_scheduler_tick_gen.sv
// Frame-rate tick counter with a single pending-tick slot and a saturating
// count of ticks that arrived while one was already pending.
module frame_tick_gen
  import frame_sched_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
  output logic       pending,
  output logic [7:0] overrun
);

  localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  logic [CW-1:0] count;
  logic          tick;
  logic          tick_pend;

  assign tick    = (count == CW'(TICK_PERIOD - 1));
  assign pending = tick | tick_pend;

  // A tick arriving in the same cycle the scheduler consumes one is kept,
  // not counted as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      tick_pend <= 1'b0;
      overrun   <= 8'd0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (take && pending) begin
        tick_pend <= tick & tick_pend;
      end else if (tick) begin
        tick_pend <= 1'b1;
        if (tick_pend && overrun != 8'hFF)
          overrun <= overrun + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Sequences per-tick SPI-flash frame reads: layered normal frames or the
// bell animation, one READ command per handshake.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEF,
  parameter int unsigned NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int unsigned BELL_OFFSET = BELL_OFFSET_DEF,
  parameter int unsigned BELL_FRAMES = BELL_FRAMES_DEF,
  parameter logic [7:0]  CMD_READ    = CMD_READ_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               frames,
  input  logic                      bell,
  frame_scheduler_if.master         rd_bus,
  output logic                      frame_ready,
  output logic                      anim_active,
  output logic [7:0]                overrun
);

  sched_state_t state;
  logic [1:0]   layer;
  logic [1:0]   next_layer;
  logic [15:0]  anim_pos;
  logic [15:0]  anim_base;
  logic         bell_q;
  logic         bell_pend;
  logic         bell_rise;
  logic         bell_clear;
  logic         take;
  logic         pending;

  assign take       = (state == IDLE);
  assign next_layer = layer + 2'd1;
  assign bell_rise  = bell & ~bell_q;
  assign bell_clear = take & pending;
  assign anim_base  = 16'(32'(BELL_OFFSET) + 32'(BELL_FRAMES) * 32'(frames[31:24]));

  frame_tick_gen #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .take   (take),
    .pending(pending),
    .overrun(overrun)
  );

  // rd_cmd/rd_first are latched only when entering ISSUE, so frames may
  // change freely while a request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      layer           <= 2'd0;
      anim_pos        <= 16'd0;
      anim_active     <= 1'b0;
      bell_q          <= 1'b0;
      bell_pend       <= 1'b0;
      frame_ready     <= 1'b0;
      rd_bus.rd_req   <= 1'b0;
      rd_bus.rd_cmd   <= 32'd0;
      rd_bus.rd_first <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      bell_q      <= bell;
      bell_pend   <= bell_rise | (bell_pend & ~bell_clear);
      case (state)
        IDLE: begin
          if (pending) begin
            layer           <= 2'd0;
            rd_bus.rd_req   <= 1'b1;
            rd_bus.rd_first <= 1'b1;
            state           <= ISSUE;
            if (bell_pend) begin
              anim_active   <= 1'b1;
              anim_pos      <= 16'd0;
              rd_bus.rd_cmd <= read_cmd(anim_base, CMD_READ, FRAME_BYTES);
            end else if (anim_active) begin
              rd_bus.rd_cmd <= read_cmd(anim_base + anim_pos, CMD_READ, FRAME_BYTES);
            end else begin
              rd_bus.rd_cmd <= read_cmd({8'h00, frames[7:0]}, CMD_READ, FRAME_BYTES);
            end
          end
        end
        ISSUE: begin
          if (rd_bus.rd_ack) begin
            rd_bus.rd_req <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (rd_bus.rd_done)
            state <= NEXT;
        end
        NEXT: begin
          if (anim_active) begin
            frame_ready <= 1'b1;
            if (anim_pos == 16'(BELL_FRAMES - 1))
              anim_active <= 1'b0;
            else
              anim_pos <= anim_pos + 16'd1;
            state <= IDLE;
          end else if (32'(layer) < NUM_LAYERS - 1) begin
            layer           <= next_layer;
            rd_bus.rd_cmd   <= read_cmd({8'h00, frames[{next_layer, 3'b000} +: 8]},
                                        CMD_READ, FRAME_BYTES);
            rd_bus.rd_first <= 1'b0;
            rd_bus.rd_req   <= 1'b1;
            state           <= ISSUE;
          end else begin
            frame_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
